hazard_control_unit: RTL and testbench

Parametrised hazard controller for the pipelined processor: generalised operand forwarding for NSRC execute-stage source operands, plus load-use stall sequencing and taken-branch flush sequencing. It sits beside the pipeline registers and drives the execute-stage operand muxes and the fetch/decode/execute stall and flush controls. The forwarding path is combinational. The stall and flush sequencing is a registered FSM, so multi-cycle load latency and deep flush windows need no extra logic elsewhere.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/hazard_control_unit_operand_forward_sel.sv | 39 +++
 rtl/hazard_control_unit.sv | 149 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller: forwarding selects, FSM states
// and the countdown-counter sizing helper.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF       = 2'b00,
        FWD_MEM_ALU  = 2'b01,
        FWD_MEM_LOAD = 2'b10,
        FWD_WB       = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } hz_state_t;

    // Counter wide enough for max(a, b), never narrower than 3 bits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 3) ? 3 : w;
    endfunction

endpackage

// File: rtl/hazard_control_unit_operand_forward_sel.sv
// Forwarding select for a single execute-stage source operand.
// MEM stage beats WB stage; register 0 optionally never matches.
module operand_forward_sel
    import hazard_pkg::*;
#(
    parameter int N            = 4,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic [N-1:0] rs,
    input  logic         rs_valid,
    input  logic         regw_m,
    input  logic         memtoreg_m,
    input  logic [N-1:0] rd_m,
    input  logic         regw_w,
    input  logic [N-1:0] rd_wb,
    output logic [1:0]   sel
);

    logic     masked;
    logic     hit_m;
    logic     hit_w;
    fwd_sel_t sel_t;

    assign masked = R0_HARDWIRED && (rs == '0);
    assign hit_m  = rs_valid && !masked && regw_m && (rd_m == rs);
    assign hit_w  = rs_valid && !masked && regw_w && (rd_wb == rs);

    always_comb begin
        sel_t = FWD_RF;
        if (hit_m) begin
            sel_t = memtoreg_m ? FWD_MEM_LOAD : FWD_MEM_ALU;
        end else if (hit_w) begin
            sel_t = FWD_WB;
        end
    end

    assign sel = sel_t;

endmodule

// File: rtl/hazard_control_unit.sv
// Operand forwarding plus load-use stall / taken-branch flush sequencing.
// First cycle of each hazard is combinational; the remainder is counted out.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int N            = 4,
    parameter int NSRC         = 2,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYC    = 1,
    parameter bit R0_HARDWIRED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regw_m,
    input  logic              regw_w,
    input  logic              memtoreg_m,
    input  logic [N-1:0]      rd_m,
    input  logic [N-1:0]      rd_wb,
    input  logic [NSRC*N-1:0] rs_e,
    input  logic [NSRC-1:0]   rs_valid_e,
    input  logic [NSRC*N-1:0] rs_d,
    input  logic [NSRC-1:0]   rs_valid_d,
    input  logic              regw_e,
    input  logic              memtoreg_e,
    input  logic [N-1:0]      rd_e,
    input  logic              branch_taken_e,
    output logic [2*NSRC-1:0] fwd_sel,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic              busy
);

    localparam int CW = cnt_width(LOAD_LAT, FLUSH_CYC);

    localparam logic [CW-1:0] LOAD_INIT  = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] FLUSH_INIT = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] ONE        = CW'(1);

    for (genvar i = 0; i < NSRC; i++) begin : g_fwd
        operand_forward_sel #(
            .N            (N),
            .R0_HARDWIRED (R0_HARDWIRED)
        ) u_sel (
            .rs         (rs_e[i*N +: N]),
            .rs_valid   (rs_valid_e[i]),
            .regw_m     (regw_m),
            .memtoreg_m (memtoreg_m),
            .rd_m       (rd_m),
            .regw_w     (regw_w),
            .rd_wb      (rd_wb),
            .sel        (fwd_sel[2*i +: 2])
        );
    end

    hz_state_t     state;
    hz_state_t     state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          lu;
    logic          stall_c;
    logic          flush_d_c;
    logic          flush_e_c;

    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (rs_valid_d[i] && (rs_d[i*N +: N] == rd_e)) begin
                lu = 1'b1;
            end
        end
        if (!(regw_e && memtoreg_e)) begin
            lu = 1'b0;
        end
        if (R0_HARDWIRED && (rd_e == '0)) begin
            lu = 1'b0;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stall_c   = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        // A taken branch overrides whatever sequence is in flight.
        if (branch_taken_e) begin
            flush_d_c = 1'b1;
            flush_e_c = 1'b1;
            if (FLUSH_CYC > 1) begin
                state_n = FLUSH;
                cnt_n   = FLUSH_INIT;
            end else begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (lu) begin
                        stall_c   = 1'b1;
                        flush_e_c = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_n = STALL;
                            cnt_n   = LOAD_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_c   = 1'b1;
                    flush_e_c = 1'b1;
                    cnt_n     = cnt - ONE;
                    if (cnt == ONE) begin
                        state_n = IDLE;
                    end
                end
                FLUSH: begin
                    flush_d_c = 1'b1;
                    cnt_n     = cnt - ONE;
                    if (cnt == ONE) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    assign stall_f = stall_c && !rst;
    assign stall_d = stall_c && !rst;
    assign flush_d = flush_d_c && !rst;
    assign flush_e = flush_e_c && !rst;
    assign busy    = (state != IDLE) && !rst;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: forwarding selects and stall/flush sequencing with
// LOAD_LAT=3, FLUSH_CYC=2, register 0 hardwired.
module tb_hazard_control_unit;

    localparam int N    = 4;
    localparam int NSRC = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              regw_m;
    logic              regw_w;
    logic              memtoreg_m;
    logic [N-1:0]      rd_m;
    logic [N-1:0]      rd_wb;
    logic [NSRC*N-1:0] rs_e;
    logic [NSRC-1:0]   rs_valid_e;
    logic [NSRC*N-1:0] rs_d;
    logic [NSRC-1:0]   rs_valid_d;
    logic              regw_e;
    logic              memtoreg_e;
    logic [N-1:0]      rd_e;
    logic              branch_taken_e;
    logic [2*NSRC-1:0] fwd_sel;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // {stall_f, stall_d, flush_d, flush_e, busy}
    logic [4:0] ctl;
    assign ctl = {stall_f, stall_d, flush_d, flush_e, busy};

    hazard_control_unit #(
        .N            (N),
        .NSRC         (NSRC),
        .LOAD_LAT     (3),
        .FLUSH_CYC    (2),
        .R0_HARDWIRED (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .regw_m         (regw_m),
        .regw_w         (regw_w),
        .memtoreg_m     (memtoreg_m),
        .rd_m           (rd_m),
        .rd_wb          (rd_wb),
        .rs_e           (rs_e),
        .rs_valid_e     (rs_valid_e),
        .rs_d           (rs_d),
        .rs_valid_d     (rs_valid_d),
        .regw_e         (regw_e),
        .memtoreg_e     (memtoreg_e),
        .rd_e           (rd_e),
        .branch_taken_e (branch_taken_e),
        .fwd_sel        (fwd_sel),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic set_lu(input logic on);
        regw_e     = on;
        memtoreg_e = on;
        rd_e       = 4'd4;
        rs_d       = {4'd4, 4'd9};
        rs_valid_d = 2'b10;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_lu(1'b1);
        branch_taken_e = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("FAIL reset_hold ctl got %b want %b", ctl, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        set_lu(1'b0);
        branch_taken_e = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("FAIL reset_idle ctl got %b want %b", ctl, 5'b00000);
        end
    endtask

    task automatic test_forward;
        @(negedge clk);
        rs_e       = {4'd5, 4'd3};
        rs_valid_e = 2'b11;
        rd_m       = 4'd3;
        regw_m     = 1'b1;
        memtoreg_m = 1'b0;
        rd_wb      = 4'd5;
        regw_w     = 1'b1;
        #1;
        checks++;
        if (fwd_sel !== 4'b1101) begin
            errors++;
            $display("FAIL fwd_mem_wb got %b want %b", fwd_sel, 4'b1101);
        end
        memtoreg_m = 1'b1;
        #1;
        checks++;
        if (fwd_sel !== 4'b1110) begin
            errors++;
            $display("FAIL fwd_load got %b want %b", fwd_sel, 4'b1110);
        end
        memtoreg_m = 1'b0;
        rd_m       = 4'd7;
        rd_wb      = 4'd7;
        rs_e       = {4'd2, 4'd7};
        #1;
        checks++;
        if (fwd_sel !== 4'b0001) begin
            errors++;
            $display("FAIL fwd_prio got %b want %b", fwd_sel, 4'b0001);
        end
        rs_e = {4'd7, 4'd7};
        rs_valid_e = 2'b10;
        #1;
        checks++;
        if (fwd_sel !== 4'b0100) begin
            errors++;
            $display("FAIL fwd_valid got %b want %b", fwd_sel, 4'b0100);
        end
        regw_m = 1'b0;
        #1;
        checks++;
        if (fwd_sel !== 4'b1100) begin
            errors++;
            $display("FAIL fwd_wb_only got %b want %b", fwd_sel, 4'b1100);
        end
        regw_m     = 1'b1;
        rd_m       = 4'd0;
        rd_wb      = 4'd0;
        rs_e       = 8'd0;
        rs_valid_e = 2'b11;
        #1;
        checks++;
        if (fwd_sel !== 4'b0000) begin
            errors++;
            $display("FAIL fwd_r0 got %b want %b", fwd_sel, 4'b0000);
        end
        regw_m = 1'b0;
        regw_w = 1'b0;
    endtask

    // Stall cycles 0..2; busy only in 1..2; idle at cycle 3.
    task automatic test_load_use;
        logic [4:0] exp;
        @(negedge clk);
        set_lu(1'b1);
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                set_lu(1'b0);
            end
            #1;
            exp = (c == 0) ? 5'b11010 :
                  (c < 3)  ? 5'b11011 : 5'b00000;
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL lu_cycle%0d ctl got %b want %b", c, ctl, exp);
            end
        end
        rd_e       = 4'd0;
        rs_d       = {4'd0, 4'd0};
        rs_valid_d = 2'b11;
        regw_e     = 1'b1;
        memtoreg_e = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("FAIL lu_r0 ctl got %b want %b", ctl, 5'b00000);
        end
        set_lu(1'b0);
    endtask

    task automatic test_branch;
        logic [4:0] exp;
        @(negedge clk);
        branch_taken_e = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                @(negedge clk);
                branch_taken_e = 1'b0;
            end
            #1;
            exp = (c == 0) ? 5'b00110 :
                  (c == 1) ? 5'b00101 : 5'b00000;
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL br_cycle%0d ctl got %b want %b", c, ctl, exp);
            end
        end
    endtask

    task automatic test_branch_vs_lu;
        @(negedge clk);
        set_lu(1'b1);
        branch_taken_e = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b00110) begin
            errors++;
            $display("FAIL br_lu_same ctl got %b want %b", ctl, 5'b00110);
        end
        @(negedge clk);
        set_lu(1'b0);
        branch_taken_e = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00101) begin
            errors++;
            $display("FAIL br_lu_flush ctl got %b want %b", ctl, 5'b00101);
        end
        @(negedge clk);
        set_lu(1'b1);
        #1;
        checks++;
        if (ctl !== 5'b11010) begin
            errors++;
            $display("FAIL st_start ctl got %b want %b", ctl, 5'b11010);
        end
        @(negedge clk);
        set_lu(1'b0);
        branch_taken_e = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b00111) begin
            errors++;
            $display("FAIL st_branch ctl got %b want %b", ctl, 5'b00111);
        end
        @(negedge clk);
        branch_taken_e = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00101) begin
            errors++;
            $display("FAIL st_br_flush ctl got %b want %b", ctl, 5'b00101);
        end
        @(negedge clk);
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("FAIL st_br_idle ctl got %b want %b", ctl, 5'b00000);
        end
    endtask

    task automatic test_rst_mid;
        @(negedge clk);
        set_lu(1'b1);
        @(negedge clk);
        set_lu(1'b0);
        #1;
        checks++;
        if (ctl !== 5'b11011) begin
            errors++;
            $display("FAIL rm_stall ctl got %b want %b", ctl, 5'b11011);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("FAIL rm_during ctl got %b want %b", ctl, 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("FAIL rm_after ctl got %b want %b", ctl, 5'b00000);
        end
    endtask

    // Load-use re-detected on the cycle the FSM returns to IDLE.
    task automatic test_back_to_back;
        logic [4:0] exp;
        @(negedge clk);
        set_lu(1'b1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(negedge clk);
                set_lu(c == 3);
            end
            #1;
            exp = (c == 0 || c == 3) ? 5'b11010 : 5'b11011;
            checks++;
            if (ctl !== exp) begin
                errors++;
                $display("FAIL b2b_cycle%0d ctl got %b want %b", c, ctl, exp);
            end
        end
        set_lu(1'b0);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (ctl !== 5'b00000) begin
            errors++;
            $display("FAIL b2b_idle ctl got %b want %b", ctl, 5'b00000);
        end
    endtask

    initial begin
        rst            = 1'b1;
        regw_m         = 1'b0;
        regw_w         = 1'b0;
        memtoreg_m     = 1'b0;
        rd_m           = '0;
        rd_wb          = '0;
        rs_e           = '0;
        rs_valid_e     = '0;
        branch_taken_e = 1'b0;
        set_lu(1'b0);
        @(negedge clk);
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_branch_vs_lu();
        test_rst_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
